// File: rtl/disp_sequencer.sv
// MAX7219 display sequencer: runs the power-up register list, then refreshes the
// digit/decode registers on request and rewrites intensity whenever it changes.
module disp_sequencer #(
  parameter logic [7:0] SCAN_LIMIT = 8'd7,
  parameter logic [7:0] TEST_OFF   = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [63:0] digits,
  input  logic [7:0]  decode,
  input  logic [3:0]  brightness,
  input  logic        drv_busy,
  output logic        drv_start,
  output logic [7:0]  drv_addr,
  output logic [7:0]  drv_data,
  output logic        ready
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic [1:0] {LIST_INIT, LIST_REFRESH, LIST_BRI} list_t;

  state_t      r_state;
  state_t      w_nextState;
  list_t       r_mode;
  logic [3:0]  r_index;
  logic        r_pending;
  logic [63:0] r_shDigits;
  logic [7:0]  r_shDecode;
  logic [63:0] r_wkDigits;
  logic [7:0]  r_wkDecode;
  logic [3:0]  r_sentBri;
  logic        r_start;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;

  logic        w_load;
  logic [15:0] w_entry;
  logic        w_startRefresh;
  logic        w_startBri;
  logic        w_advance;
  logic [3:0]  w_nextIdx;
  logic [3:0]  w_lastIdx;
  logic [2:0]  w_digIdx;
  logic [15:0] w_listEntry;

  // Entry that follows the current one in the active list; digit entries map onto
  // addresses 1..8, so the digit number is the low index bits minus the list offset.
  always_comb begin
    w_nextIdx   = r_index + 4'd1;
    w_listEntry = 16'h0000;
    w_lastIdx   = 4'd0;
    w_digIdx    = 3'd0;
    case (r_mode)
      LIST_INIT: begin
        w_lastIdx = 4'd12;
        w_digIdx  = w_nextIdx[2:0] - 3'd5;
        case (w_nextIdx)
          4'd1:    w_listEntry = {8'h0B, SCAN_LIMIT};
          4'd2:    w_listEntry = {8'h09, r_shDecode};
          4'd3:    w_listEntry = {8'h0A, 4'h0, brightness};
          4'd4:    w_listEntry = {8'h0C, 8'h01};
          default: w_listEntry = {{5'b00000, w_digIdx} + 8'd1, r_shDigits[{w_digIdx, 3'b000} +: 8]};
        endcase
      end
      LIST_REFRESH: begin
        w_lastIdx   = 4'd8;
        w_digIdx    = w_nextIdx[2:0] - 3'd1;
        w_listEntry = {{5'b00000, w_digIdx} + 8'd1, r_wkDigits[{w_digIdx, 3'b000} +: 8]};
      end
      default: w_lastIdx = 4'd0;
    endcase
  end

  always_comb begin
    w_nextState    = r_state;
    w_load         = 1'b0;
    w_entry        = 16'h0000;
    w_startRefresh = 1'b0;
    w_startBri     = 1'b0;
    w_advance      = 1'b0;
    case (r_state)
      INIT: begin
        w_nextState = ISSUE;
        w_load      = 1'b1;
        w_entry     = {8'h0F, TEST_OFF};
      end
      IDLE: begin
        // Intensity wins over a pending refresh; the refresh starts on the next IDLE visit.
        if (brightness != r_sentBri) begin
          w_nextState = ISSUE;
          w_load      = 1'b1;
          w_startBri  = 1'b1;
          w_entry     = {8'h0A, 4'h0, brightness};
        end else if (r_pending) begin
          w_nextState    = ISSUE;
          w_load         = 1'b1;
          w_startRefresh = 1'b1;
          w_entry        = {8'h09, r_shDecode};
        end
      end
      ISSUE:   w_nextState = WAIT_HI;
      WAIT_HI: if (drv_busy) w_nextState = WAIT_LO;
      WAIT_LO: begin
        if (!drv_busy) begin
          if (r_index == w_lastIdx) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = ISSUE;
            w_load      = 1'b1;
            w_advance   = 1'b1;
            w_entry     = w_listEntry;
          end
        end
      end
      default: w_nextState = INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_mode     <= LIST_INIT;
      r_index    <= 4'd0;
      r_pending  <= 1'b0;
      r_shDigits <= 64'd0;
      r_shDecode <= 8'd0;
      r_wkDigits <= 64'd0;
      r_wkDecode <= 8'd0;
      r_sentBri  <= 4'd0;
      r_start    <= 1'b0;
      r_addr     <= 8'd0;
      r_data     <= 8'd0;
    end else begin
      r_state <= w_nextState;
      r_start <= (r_state == ISSUE);
      if (w_load) begin
        r_addr <= w_entry[15:8];
        r_data <= w_entry[7:0];
        if (w_entry[15:8] == 8'h0A) r_sentBri <= w_entry[3:0];
      end
      if (w_advance) r_index <= w_nextIdx;
      if (w_startBri) begin
        r_mode  <= LIST_BRI;
        r_index <= 4'd0;
      end
      if (w_startRefresh) begin
        r_mode     <= LIST_REFRESH;
        r_index    <= 4'd0;
        r_wkDigits <= r_shDigits;
        r_wkDecode <= r_shDecode;
        r_pending  <= 1'b0;
      end
      // A capture on the refresh-start edge must survive the clear above.
      if (update) begin
        r_shDigits <= digits;
        r_shDecode <= decode;
        r_pending  <= 1'b1;
      end
    end
  end

  assign drv_start = r_start;
  assign drv_addr  = r_addr;
  assign drv_data  = r_data;
  assign ready     = (r_state == IDLE) && !r_pending && (brightness == r_sentBri);

endmodule
